// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master) and memory (slave).
interface fetch_stage_if #(
  parameter int WIDTH = 22
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_rdata;
  logic             imem_ready;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the multi-cycle imem request and the IF/ID register.
module fetch_stage #(
  parameter int               WIDTH    = 22,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] PC_STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             flush_d,
  input  logic             pc_src_in,
  input  logic [WIDTH-1:0] branch_target_in,
  fetch_stage_if.master    imem,
  output logic [WIDTH-1:0] instruction_decode_out,
  output logic [WIDTH-1:0] pc_plus_8_out,
  output logic             valid_decode_out
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc_f;
  logic [WIDTH-1:0] r_drop_addr;
  logic [WIDTH-1:0] r_skid_instr;
  logic [WIDTH-1:0] r_skid_pc;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_pc8;
  logic             r_valid;
  logic             w_accept;

  function automatic logic [WIDTH-1:0] pc_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  localparam logic [WIDTH-1:0] PC_STEP2 = PC_STEP + PC_STEP;

  // DROP keeps presenting the abandoned address while pc_f already holds the redirect target.
  assign imem.imem_req  = ~rst & (r_state != HOLD);
  assign imem.imem_addr = (r_state == DROP) ? r_drop_addr : r_pc_f;
  assign w_accept       = imem.imem_req & imem.imem_ready;

  assign instruction_decode_out = r_instr;
  assign pc_plus_8_out          = r_pc8;
  assign valid_decode_out       = r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FETCH;
      r_pc_f       <= RESET_PC;
      r_drop_addr  <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_instr      <= '0;
      r_pc8        <= '0;
      r_valid      <= 1'b0;
    end else begin
      if (pc_src_in) begin
        r_pc_f <= branch_target_in;
        case (r_state)
          FETCH: begin
            if (w_accept) begin
              r_state <= FETCH;
            end else begin
              r_state     <= DROP;
              r_drop_addr <= r_pc_f;
            end
          end
          DROP:    if (w_accept) r_state <= FETCH;
          default: r_state <= FETCH;
        endcase
      end else begin
        case (r_state)
          FETCH: begin
            if (w_accept && !stall_f) begin
              r_pc_f <= pc_add(r_pc_f, PC_STEP);
            end else if (w_accept) begin
              r_skid_instr <= imem.imem_rdata;
              r_skid_pc    <= r_pc_f;
              r_state      <= HOLD;
            end
          end
          HOLD: begin
            if (!stall_f) begin
              r_pc_f  <= pc_add(r_pc_f, PC_STEP);
              r_state <= FETCH;
            end
          end
          DROP:    if (w_accept) r_state <= FETCH;
          default: r_state <= FETCH;
        endcase
      end

      // IF/ID register: flush beats stall, stall beats any load; redirected words never enter.
      if (flush_d) begin
        r_instr <= '0;
        r_pc8   <= '0;
        r_valid <= 1'b0;
      end else if (!stall_f) begin
        if (!pc_src_in && r_state == FETCH && w_accept) begin
          r_instr <= imem.imem_rdata;
          r_pc8   <= pc_add(r_pc_f, PC_STEP2);
          r_valid <= 1'b1;
        end else if (!pc_src_in && r_state == HOLD) begin
          r_instr <= r_skid_instr;
          r_pc8   <= pc_add(r_skid_pc, PC_STEP2);
          r_valid <= 1'b1;
        end else begin
          r_instr <= '0;
          r_pc8   <= '0;
          r_valid <= 1'b0;
        end
      end
    end
  end

endmodule
